// File: rtl/dram_bank_ctrl.sv
// Per-bank DDR2 sequencer. Holds one bank request, splits it into ACT/RD/WR/PRE/REF
// command requests for the scheduler and enforces the bank-local timings
// (tRCD, tRP, tRAS, tRFC, tRTP, tWTP) under an open-page policy.
module dram_bank_ctrl #(
    parameter int unsigned BANK_ID      = 0,
    parameter int unsigned BA_W         = 3,
    parameter int unsigned RA_W         = 14,
    parameter int unsigned CA_W         = 11,
    parameter int unsigned ID_W         = 4,
    parameter int unsigned T_W          = 8,
    parameter int unsigned BURST_CA_INC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [ID_W-1:0] req_id_i,
    input  logic [RA_W-1:0] req_ra_i,
    input  logic [CA_W-1:0] req_ca_i,
    input  logic [3:0]      req_len_i,
    input  logic            req_wr_i,
    input  logic [T_W-1:0]  t_rcd_i,
    input  logic [T_W-1:0]  t_rp_i,
    input  logic [T_W-1:0]  t_ras_i,
    input  logic [T_W-1:0]  t_rfc_i,
    input  logic [T_W-1:0]  t_rtp_i,
    input  logic [T_W-1:0]  t_wtp_i,
    input  logic            ref_pend_i,
    output logic            act_req_o,
    output logic            rd_req_o,
    output logic            wr_req_o,
    output logic            pre_req_o,
    output logic            ref_req_o,
    input  logic            act_gnt_i,
    input  logic            rd_gnt_i,
    input  logic            wr_gnt_i,
    input  logic            pre_gnt_i,
    input  logic            ref_gnt_i,
    output logic [BA_W-1:0] ba_o,
    output logic [RA_W-1:0] ra_o,
    output logic [CA_W-1:0] ca_o,
    output logic [ID_W-1:0] id_o,
    output logic            bank_idle_o
);

    typedef enum logic [1:0] {StClosed, StOpen, StPreWait, StRefWait} state_e;

    // Counter load value and per-cycle decrement: both are max(x - 1, 0).
    function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - T_W'(1);
    endfunction

    state_e          state_q, state_d;
    logic            hold_valid_q, hold_valid_d;
    logic [ID_W-1:0] hold_id_q, hold_id_d;
    logic [RA_W-1:0] hold_ra_q, hold_ra_d;
    logic [CA_W-1:0] hold_ca_q, hold_ca_d;
    logic [3:0]      hold_len_q, hold_len_d;
    logic            hold_wr_q, hold_wr_d;
    logic [3:0]      cmd_cnt_q, cmd_cnt_d;
    logic [RA_W-1:0] open_ra_q, open_ra_d;
    logic [T_W-1:0]  rcd_cnt_q, rcd_cnt_d;
    logic [T_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic [T_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [T_W-1:0]  rp_cnt_q, rp_cnt_d;
    // Outstanding, not-yet-granted request; keeps it stable when ref_pend_i rises.
    logic [4:0]      lock_q, lock_d;

    logic [4:0]      new_vec, req_vec, gnt_vec;
    logic            new_act, new_rd, new_wr, new_pre, new_ref;
    logic            fire_act, fire_rd, fire_wr, fire_pre, fire_ref;
    logic            wait_done, eff_closed, row_hit, row_miss, ref_boundary;
    logic [T_W-1:0]  col_t;
    logic [CA_W-1:0] ca_off;

    // Wait states whose counter has expired behave exactly like CLOSED, so the
    // dependent ACT/REF can be requested in the cycle the counter reaches 0.
    assign wait_done    = ((state_q == StPreWait) || (state_q == StRefWait)) && (rp_cnt_q == '0);
    assign eff_closed   = (state_q == StClosed) || wait_done;
    assign row_hit      = hold_valid_q && (hold_ra_q == open_ra_q);
    assign row_miss     = hold_valid_q && (hold_ra_q != open_ra_q);
    assign ref_boundary = ref_pend_i && (cmd_cnt_q == '0);

    // Fresh command request from registered state and counters only.
    always_comb begin
        new_act = 1'b0;
        new_rd  = 1'b0;
        new_wr  = 1'b0;
        new_pre = 1'b0;
        new_ref = 1'b0;
        if (eff_closed) begin
            if (ref_pend_i) begin
                new_ref = 1'b1;
            end else if (hold_valid_q) begin
                new_act = 1'b1;
            end
        end else if (state_q == StOpen) begin
            if (row_hit && (rcd_cnt_q == '0) && !ref_boundary) begin
                new_wr = hold_wr_q;
                new_rd = !hold_wr_q;
            end else if ((row_miss || ref_boundary) && (ras_cnt_q == '0) &&
                         (pre_cnt_q == '0)) begin
                new_pre = 1'b1;
            end
        end
    end

    assign new_vec = {new_ref, new_pre, new_wr, new_rd, new_act};
    assign req_vec = (lock_q != '0) ? lock_q : new_vec;
    assign gnt_vec = {ref_gnt_i, pre_gnt_i, wr_gnt_i, rd_gnt_i, act_gnt_i};
    assign {ref_req_o, pre_req_o, wr_req_o, rd_req_o, act_req_o} = req_vec;
    // Grants without a matching request are masked off here.
    assign {fire_ref, fire_pre, fire_wr, fire_rd, fire_act} = req_vec & gnt_vec;

    assign col_t  = fire_wr ? dec_sat(t_wtp_i) : dec_sat(t_rtp_i);
    assign ca_off = CA_W'(cmd_cnt_q) * CA_W'(BURST_CA_INC);

    assign req_ready_o = !hold_valid_q;
    assign ba_o        = BA_W'(BANK_ID);
    assign ra_o        = hold_ra_q;
    assign ca_o        = hold_ca_q + ca_off;
    assign id_o        = hold_id_q;
    assign bank_idle_o = eff_closed && !hold_valid_q;

    // Next-state: FSM transitions, timing counter loads and request capture.
    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_id_d    = hold_id_q;
        hold_ra_d    = hold_ra_q;
        hold_ca_d    = hold_ca_q;
        hold_len_d   = hold_len_q;
        hold_wr_d    = hold_wr_q;
        cmd_cnt_d    = cmd_cnt_q;
        open_ra_d    = open_ra_q;
        rcd_cnt_d    = dec_sat(rcd_cnt_q);
        ras_cnt_d    = dec_sat(ras_cnt_q);
        pre_cnt_d    = dec_sat(pre_cnt_q);
        rp_cnt_d     = dec_sat(rp_cnt_q);
        lock_d       = req_vec & ~gnt_vec;

        if (wait_done) begin
            state_d = StClosed;
        end
        if (fire_ref) begin
            rp_cnt_d = dec_sat(t_rfc_i);
            state_d  = StRefWait;
        end
        if (fire_act) begin
            open_ra_d = hold_ra_q;
            rcd_cnt_d = dec_sat(t_rcd_i);
            ras_cnt_d = dec_sat(t_ras_i);
            state_d   = StOpen;
        end
        if (fire_pre) begin
            rp_cnt_d = dec_sat(t_rp_i);
            state_d  = StPreWait;
        end
        if (fire_rd || fire_wr) begin
            pre_cnt_d = (pre_cnt_q > col_t) ? pre_cnt_q : col_t;
            if (cmd_cnt_q == hold_len_q) begin
                hold_valid_d = 1'b0;
                cmd_cnt_d    = '0;
            end else begin
                cmd_cnt_d = cmd_cnt_q + 4'd1;
            end
        end
        if (req_valid_i && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_id_d    = req_id_i;
            hold_ra_d    = req_ra_i;
            hold_ca_d    = req_ca_i;
            hold_len_d   = req_len_i;
            hold_wr_d    = req_wr_i;
            cmd_cnt_d    = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StClosed;
            hold_valid_q <= 1'b0;
            hold_id_q    <= '0;
            hold_ra_q    <= '0;
            hold_ca_q    <= '0;
            hold_len_q   <= '0;
            hold_wr_q    <= 1'b0;
            cmd_cnt_q    <= '0;
            open_ra_q    <= '0;
            rcd_cnt_q    <= '0;
            ras_cnt_q    <= '0;
            pre_cnt_q    <= '0;
            rp_cnt_q     <= '0;
            lock_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_id_q    <= hold_id_d;
            hold_ra_q    <= hold_ra_d;
            hold_ca_q    <= hold_ca_d;
            hold_len_q   <= hold_len_d;
            hold_wr_q    <= hold_wr_d;
            cmd_cnt_q    <= cmd_cnt_d;
            open_ra_q    <= open_ra_d;
            rcd_cnt_q    <= rcd_cnt_d;
            ras_cnt_q    <= ras_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            rp_cnt_q     <= rp_cnt_d;
            lock_q       <= lock_d;
        end
    end

    // A grant for a command that is not being requested is a scheduler bug.
    gnt_matches_req: assert property (@(posedge clk) disable iff (!rst_n)
        ((gnt_vec & ~req_vec) == '0));
    req_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_vec));

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Randomized bench for dram_bank_ctrl. The bench plays address decoder, refresh timer
// and scheduler; a timestamp-based bank model predicts every request and output.
module tb_dram_bank_ctrl;

    localparam int unsigned BankId = 5;
    localparam int unsigned BaW    = 3;
    localparam int unsigned RaW    = 14;
    localparam int unsigned CaW    = 11;
    localparam int unsigned IdW    = 4;
    localparam int unsigned TW     = 8;
    localparam int unsigned Inc    = 8;

    localparam int CmdNone = 0, CmdAct = 1, CmdRd = 2, CmdWr = 3, CmdPre = 4, CmdRef = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [IdW-1:0] req_id_i = '0;
    logic [RaW-1:0] req_ra_i = '0;
    logic [CaW-1:0] req_ca_i = '0;
    logic [3:0]     req_len_i = '0;
    logic           req_wr_i = 1'b0;
    logic [TW-1:0]  t_rcd_i = 8'd3, t_rp_i = 8'd4, t_ras_i = 8'd10;
    logic [TW-1:0]  t_rfc_i = 8'd20, t_rtp_i = 8'd2, t_wtp_i = 8'd6;
    logic           ref_pend_i = 1'b0;
    logic           act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o;
    logic           act_gnt_i = 1'b0, rd_gnt_i = 1'b0, wr_gnt_i = 1'b0;
    logic           pre_gnt_i = 1'b0, ref_gnt_i = 1'b0;
    logic [BaW-1:0] ba_o;
    logic [RaW-1:0] ra_o;
    logic [CaW-1:0] ca_o;
    logic [IdW-1:0] id_o;
    logic           bank_idle_o;

    always #5 clk = ~clk;

    dram_bank_ctrl #(
        .BANK_ID      (BankId),
        .BA_W         (BaW),
        .RA_W         (RaW),
        .CA_W         (CaW),
        .ID_W         (IdW),
        .T_W          (TW),
        .BURST_CA_INC (Inc)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_id_i    (req_id_i),
        .req_ra_i    (req_ra_i),
        .req_ca_i    (req_ca_i),
        .req_len_i   (req_len_i),
        .req_wr_i    (req_wr_i),
        .t_rcd_i     (t_rcd_i),
        .t_rp_i      (t_rp_i),
        .t_ras_i     (t_ras_i),
        .t_rfc_i     (t_rfc_i),
        .t_rtp_i     (t_rtp_i),
        .t_wtp_i     (t_wtp_i),
        .ref_pend_i  (ref_pend_i),
        .act_req_o   (act_req_o),
        .rd_req_o    (rd_req_o),
        .wr_req_o    (wr_req_o),
        .pre_req_o   (pre_req_o),
        .ref_req_o   (ref_req_o),
        .act_gnt_i   (act_gnt_i),
        .rd_gnt_i    (rd_gnt_i),
        .wr_gnt_i    (wr_gnt_i),
        .pre_gnt_i   (pre_gnt_i),
        .ref_gnt_i   (ref_gnt_i),
        .ba_o        (ba_o),
        .ra_o        (ra_o),
        .ca_o        (ca_o),
        .id_o        (id_o),
        .bank_idle_o (bank_idle_o)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;

    // Bank model: timestamps (cycle numbers) at which each dependent command is legal.
    bit             m_open;
    logic [RaW-1:0] m_row;
    int unsigned    m_closed_at, m_col_ok, m_ras_ok, m_pre_ok;
    int             m_pend;
    bit             m_held;
    logic [IdW-1:0] h_id;
    logic [RaW-1:0] h_ra;
    logic [CaW-1:0] h_ca;
    logic [3:0]     h_len;
    bit             h_wr;
    int unsigned    m_beats;
    bit             ref_clear;
    bit             ref_en = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned at_least1(input logic [TW-1:0] t);
        return (t == '0) ? 1 : int'(t);
    endfunction

    function automatic logic [4:0] cmd_vec(input int c);
        case (c)
            CmdAct:  return 5'b00001;
            CmdRd:   return 5'b00010;
            CmdWr:   return 5'b00100;
            CmdPre:  return 5'b01000;
            CmdRef:  return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // Command the bank should be requesting in the current cycle.
    function automatic int exp_cmd();
        bit boundary;
        if (m_pend != CmdNone) return m_pend;
        if (!m_open) begin
            if (cyc < m_closed_at) return CmdNone;
            if (ref_pend_i) return CmdRef;
            if (m_held) return CmdAct;
            return CmdNone;
        end
        boundary = ref_pend_i && (m_beats == 0);
        if (m_held && h_ra == m_row && cyc >= m_col_ok && !boundary) return h_wr ? CmdWr : CmdRd;
        if (((m_held && h_ra != m_row) || boundary) && cyc >= m_ras_ok && cyc >= m_pre_ok)
            return CmdPre;
        return CmdNone;
    endfunction

    task automatic model_reset();
        m_open = 0; m_row = '0; m_closed_at = 0; m_col_ok = 0; m_ras_ok = 0; m_pre_ok = 0;
        m_pend = CmdNone; m_held = 0; m_beats = 0; ref_clear = 0;
        h_id = '0; h_ra = '0; h_ca = '0; h_len = '0; h_wr = 0;
    endtask

    task automatic rand_timings();
        t_rcd_i = TW'($urandom_range(6));
        t_rp_i  = TW'($urandom_range(6));
        t_ras_i = TW'($urandom_range(12));
        t_rfc_i = TW'($urandom_range(25));
        t_rtp_i = TW'($urandom_range(5));
        t_wtp_i = TW'($urandom_range(8));
    endtask

    // One clock cycle: drive stimulus, check outputs against the model, grant, update model.
    task automatic step(input int unsigned gnt_pct);
        int             e;
        logic [4:0]     dut_vec;
        logic [CaW-1:0] exp_ca;
        bit             g, held_now;
        int unsigned    t;
        @(negedge clk);
        if (ref_clear) begin
            ref_pend_i = 1'b0;
            ref_clear  = 0;
        end else if (ref_en && !ref_pend_i && $urandom_range(79) == 0) begin
            ref_pend_i = 1'b1;
        end
        req_valid_i = ($urandom_range(3) == 0);
        req_id_i    = IdW'($urandom);
        req_ra_i    = RaW'($urandom_range(3));
        req_ca_i    = CaW'($urandom);
        req_len_i   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(2));
        req_wr_i    = 1'($urandom_range(1));
        #1;
        e = exp_cmd();
        dut_vec = {ref_req_o, pre_req_o, wr_req_o, rd_req_o, act_req_o};
        check_eq("req_vec", 32'(dut_vec), 32'(cmd_vec(e)));
        check_eq("req_ready", 32'(req_ready_o), 32'(!m_held));
        check_eq("bank_idle", 32'(bank_idle_o), 32'(!m_open && cyc >= m_closed_at && !m_held));
        if (e == CmdAct) check_eq("act_ra", 32'(ra_o), 32'(h_ra));
        if (e == CmdRd || e == CmdWr) begin
            exp_ca = h_ca + CaW'(m_beats * Inc);
            check_eq("col_ca", 32'(ca_o), 32'(exp_ca));
            check_eq("col_id", 32'(id_o), 32'(h_id));
        end
        g = (e != CmdNone) && (dut_vec == cmd_vec(e)) && ($urandom_range(99) < gnt_pct);
        {ref_gnt_i, pre_gnt_i, wr_gnt_i, rd_gnt_i, act_gnt_i} = g ? cmd_vec(e) : 5'b0;
        @(posedge clk);
        held_now = m_held;
        if (g) begin
            case (e)
                CmdAct: begin
                    m_open = 1; m_row = h_ra;
                    m_col_ok = cyc + at_least1(t_rcd_i);
                    m_ras_ok = cyc + at_least1(t_ras_i);
                end
                CmdRd, CmdWr: begin
                    // Recovery window extends, never shortens, the pending one.
                    t = cyc + at_least1((e == CmdWr) ? t_wtp_i : t_rtp_i);
                    m_pre_ok = (m_pre_ok + 1 > t) ? m_pre_ok + 1 : t;
                    if (m_beats == int'(h_len)) begin
                        m_held = 0; m_beats = 0;
                    end else begin
                        m_beats++;
                    end
                end
                CmdPre: begin
                    m_open = 0; m_closed_at = cyc + at_least1(t_rp_i);
                end
                CmdRef: begin
                    m_closed_at = cyc + at_least1(t_rfc_i); ref_clear = 1;
                end
                default: ;
            endcase
        end
        m_pend = (e != CmdNone && !g) ? e : CmdNone;
        if (req_valid_i && !held_now) begin
            m_held = 1; m_beats = 0;
            h_id = req_id_i; h_ra = req_ra_i; h_ca = req_ca_i; h_len = req_len_i; h_wr = req_wr_i;
        end
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        ref_pend_i = 1'b0;
        req_valid_i = 1'b0;
        {ref_gnt_i, pre_gnt_i, wr_gnt_i, rd_gnt_i, act_gnt_i} = 5'b0;
        #1;
        check_eq("rst_reqs", 32'({ref_req_o, pre_req_o, wr_req_o, rd_req_o, act_req_o}), 32'(0));
        check_eq("rst_ready", 32'(req_ready_o), 32'(1));
        check_eq("rst_idle", 32'(bank_idle_o), 32'(1));
        check_eq("rst_ra", 32'(ra_o), 32'(0));
        check_eq("rst_ca", 32'(ca_o), 32'(0));
        check_eq("rst_id", 32'(id_o), 32'(0));
        check_eq("ba_const", 32'(ba_o), 32'(BankId));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        #1 rst_n = 1'b0;
        reset_pulse();

        // Phase 0 uses the nominal timings with instant grants; later phases randomize.
        for (int p = 0; p < 4 && failures <= 20; p++) begin
            if (p != 0) rand_timings();
            for (int i = 0; i < 700 && failures <= 20; i++) begin
                step((p == 0) ? 100 : ((p == 1) ? 70 : ((p == 2) ? 35 : 100)));
                if (p == 3 && i % 97 == 96) rand_timings();
            end
        end

        // Reset while an ACT request is waiting for its grant.
        reset_pulse();
        ref_en = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(0);
            found = (m_pend == CmdAct);
        end
        check_eq("act_wait_reached", 32'(found), 32'(1));
        reset_pulse();
        ref_en = 1'b1;

        for (int i = 0; i < 600 && failures <= 20; i++) step(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
